// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the word-packing UART receiver:
//   - rx_state_t : receiver state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   - DEFAULT_OVERSAMPLE / DEFAULT_BYTES_PER_WORD : default parameter values
//   - MID_SAMPLE : mid-bit sample index for the default oversample rate
//   - mid_index() : mid-bit sample index for any oversample rate
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_OVERSAMPLE     = 16;
  localparam int DEFAULT_BYTES_PER_WORD = 4;
  localparam int MID_SAMPLE             = DEFAULT_OVERSAMPLE / 2 - 1;

  // The sample is taken one count before the arithmetic centre of the bit so
  // that it lands in the middle of the stable region after synchronizer delay.
  function automatic logic [3:0] mid_index(input int oversample);
    return 4'(oversample / 2 - 1);
  endfunction

endpackage

// File: rtl/uart_word_pack.sv
// uart_word_pack
// Packs a stream of received bytes into little-endian words.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   byte_data      : byte to store in the current lane
//   byte_strobe    : byte_data is valid this cycle
//   clear          : restart the word at lane 0 (resynchronisation)
//   word_data      : assembled word; lanes not yet rewritten keep old contents
//   word_strobe    : one-clock pulse when the last lane of a word was written
module uart_word_pack #(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    byte_data,
  input  logic                          byte_strobe,
  input  logic                          clear,
  output logic [8*BYTES_PER_WORD-1:0]   word_data,
  output logic                          word_strobe
);

  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] byte_index;

  // Lane write, word strobe and lane pointer. The strobe is registered on the
  // same edge as the byte it completes, so it lines up with the byte flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_index  <= '0;
      word_data   <= '0;
      word_strobe <= 1'b0;
    end else begin
      word_strobe <= 1'b0;
      if (byte_strobe) begin
        word_data[byte_index*8 +: 8] <= byte_data;
        if (byte_index == LAST_LANE) begin
          byte_index  <= '0;
          word_strobe <= 1'b1;
        end else begin
          byte_index <= byte_index + 1'b1;
        end
      end else if (clear) begin
        byte_index <= '0;
      end
    end
  end

endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word
// Oversampling UART receiver (8N1, LSB first) with optional word packing.
// Optional feature macro: UART_RX_WORD_PACK_EN enables word packing; without
// it word_valid and word_data are tied to 0.
// Ports:
//   clock, reset    : system clock, synchronous active-high reset
//   baud_tick       : one-clock enable at OVERSAMPLE x baud rate
//   UART_ENB        : receiver enable, low forces IDLE and drops the frame
//   rx              : asynchronous serial input, idles high
//   wb_flag/wb_data : one-clock pulse with the last correctly framed byte
//   word_valid      : one-clock pulse when word_data holds a complete word
//   word_data       : assembled word, first byte in [7:0]
//   frame_error     : one-clock pulse when the stop bit was sampled low
//   read_state_out  : current state encoding
//   sample_count    : oversample counter within the current bit
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE     = DEFAULT_OVERSAMPLE,
  parameter int BYTES_PER_WORD = DEFAULT_BYTES_PER_WORD
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        baud_tick,
  input  logic                        UART_ENB,
  input  logic                        rx,
  output logic                        wb_flag,
  output logic [7:0]                  wb_data,
  output logic                        word_valid,
  output logic [8*BYTES_PER_WORD-1:0] word_data,
  output logic                        frame_error,
  output logic [1:0]                  read_state_out,
  output logic [3:0]                  sample_count
);

  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID         = mid_index(OVERSAMPLE);

  logic      rx_meta;
  logic      rx_sync;
  rx_state_t state;
  logic [2:0] bit_count;
  logic [7:0] shift_reg;

  // Two-flop synchronizer; both flops reset to the idle line level so a
  // reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receive FSM. Pulse outputs default low every clock so each event is a
  // single-cycle pulse. Disabling the receiver overrides baud_tick so an
  // aborted frame never produces a pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      sample_count <= '0;
      bit_count    <= '0;
      shift_reg    <= '0;
      wb_data      <= '0;
      wb_flag      <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      wb_flag     <= 1'b0;
      frame_error <= 1'b0;
      if (!UART_ENB) begin
        state        <= IDLE;
        sample_count <= '0;
        bit_count    <= '0;
      end else if (baud_tick) begin
        case (state)
          IDLE: begin
            sample_count <= '0;
            bit_count    <= '0;
            if (!rx_sync) state <= START;
          end
          START: begin
            if (sample_count == MID && rx_sync) begin
              state        <= IDLE;
              sample_count <= '0;
            end else if (sample_count == LAST_SAMPLE) begin
              state        <= DATA;
              sample_count <= '0;
              bit_count    <= '0;
            end else begin
              sample_count <= sample_count + 4'd1;
            end
          end
          DATA: begin
            if (sample_count == MID) shift_reg[bit_count] <= rx_sync;
            if (sample_count == LAST_SAMPLE) begin
              sample_count <= '0;
              if (bit_count == 3'd7) state <= STOP;
              else bit_count <= bit_count + 3'd1;
            end else begin
              sample_count <= sample_count + 4'd1;
            end
          end
          STOP: begin
            // Decide at mid-stop and leave at once so a start bit that
            // follows a short stop bit is not missed.
            if (sample_count == MID) begin
              state        <= IDLE;
              sample_count <= '0;
              if (rx_sync) begin
                wb_data <= shift_reg;
                wb_flag <= 1'b1;
              end else begin
                frame_error <= 1'b1;
              end
            end else begin
              sample_count <= sample_count + 4'd1;
            end
          end
          default: begin
            state        <= IDLE;
            sample_count <= '0;
          end
        endcase
      end
    end
  end

  assign read_state_out = state;

`ifdef UART_RX_WORD_PACK_EN
  logic stop_decision;
  logic byte_accept;
  logic word_clear;

  // These mirror the STOP-state decision so the packer updates on the same
  // edge that raises wb_flag / frame_error.
  assign stop_decision = UART_ENB && baud_tick && (state == STOP) && (sample_count == MID);
  assign byte_accept   = stop_decision && rx_sync;
  assign word_clear    = (stop_decision && !rx_sync) || !UART_ENB;

  uart_word_pack #(
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_word_pack (
    .clock      (clock),
    .reset      (reset),
    .byte_data  (shift_reg),
    .byte_strobe(byte_accept),
    .clear      (word_clear),
    .word_data  (word_data),
    .word_strobe(word_valid)
  );
`else
  assign word_valid = 1'b0;
  assign word_data  = '0;
`endif

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word
// Self-checking bench for uart_rx_word. Frames are driven bit by bit in units
// of baud ticks; a byte/word level model predicts the pulses and data for each
// frame. Follows UART_RX_WORD_PACK_EN to pick the packing or no-packing model.
module tb_uart_rx_word;

  localparam int OS = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        baud_tick = 1'b0;
  logic        uart_enb = 1'b1;
  logic        rx = 1'b1;
  logic        wb_flag;
  logic [7:0]  wb_data;
  logic        word_valid;
  logic [31:0] word_data;
  logic        frame_error;
  logic [1:0]  read_state_out;
  logic [3:0]  sample_count;

  int compared = 0;
  int mismatched = 0;

  // observed events since the last frame start
  int          wb_pulses = 0;
  int          fe_pulses = 0;
  int          wv_pulses = 0;
  logic [7:0]  last_wb = 8'h00;
  logic [31:0] last_word = 32'h0;
  logic        prev_wb = 1'b0;
  logic        prev_fe = 1'b0;
  logic        prev_wv = 1'b0;

  // reference model
  logic [7:0]  m_lanes [4];
  int          m_idx = 0;
  logic [7:0]  m_wb = 8'h00;
  int          tick_phase = 0;

  uart_rx_word #(
    .OVERSAMPLE    (OS),
    .BYTES_PER_WORD(4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .baud_tick     (baud_tick),
    .UART_ENB      (uart_enb),
    .rx            (rx),
    .wb_flag       (wb_flag),
    .wb_data       (wb_data),
    .word_valid    (word_valid),
    .word_data     (word_data),
    .frame_error   (frame_error),
    .read_state_out(read_state_out),
    .sample_count  (sample_count)
  );

  always #5 clock = ~clock;

  // baud_tick: one clock in three, changed on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      tick_phase = (tick_phase + 1) % 3;
      baud_tick  = (tick_phase == 0);
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // event monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (wb_flag === 1'b1) begin
      wb_pulses++;
      last_wb = wb_data;
      checkOutput("wb_fe_exclusive", {31'b0, frame_error}, 32'd0);
      checkOutput("wb_pulse_width", {31'b0, prev_wb}, 32'd0);
    end
    if (frame_error === 1'b1) begin
      fe_pulses++;
      checkOutput("fe_pulse_width", {31'b0, prev_fe}, 32'd0);
    end
    if (word_valid === 1'b1) begin
      wv_pulses++;
      last_word = word_data;
      checkOutput("wv_with_wb", {31'b0, wb_flag}, 32'd1);
      checkOutput("wv_pulse_width", {31'b0, prev_wv}, 32'd0);
    end
    prev_wb = wb_flag;
    prev_fe = frame_error;
    prev_wv = word_valid;
  end

  function automatic logic [31:0] model_word();
`ifdef UART_RX_WORD_PACK_EN
    return {m_lanes[3], m_lanes[2], m_lanes[1], m_lanes[0]};
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_lanes[i] = 8'h00;
    m_idx = 0;
    m_wb  = 8'h00;
  endtask

  task automatic clear_events();
    wb_pulses = 0;
    fe_pulses = 0;
    wv_pulses = 0;
  endtask

  // wait for n baud ticks, then step just past the edge
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clock); while (baud_tick !== 1'b1);
    end
    #1;
  endtask

  // send one frame, update the model and check the frame's outcome
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    int exp_wv;
    exp_wv = 0;
    clear_events();
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_ticks(OS);
    end
    rx = stop_bit;
    wait_ticks(OS);
    rx = 1'b1;
    wait_ticks($urandom_range(0, 4));

    if (stop_bit) begin
      m_wb = b;
`ifdef UART_RX_WORD_PACK_EN
      m_lanes[m_idx] = b;
      m_idx++;
      if (m_idx == 4) begin
        m_idx  = 0;
        exp_wv = 1;
      end
`endif
    end else begin
      m_idx = 0;
    end

    checkOutput("wb_pulses", wb_pulses, stop_bit ? 32'd1 : 32'd0);
    checkOutput("fe_pulses", fe_pulses, stop_bit ? 32'd0 : 32'd1);
    checkOutput("wb_data", {24'b0, wb_data}, {24'b0, m_wb});
    checkOutput("wv_pulses", wv_pulses, exp_wv);
    checkOutput("word_data", word_data, model_word());
    if (exp_wv == 1) checkOutput("word_at_valid", last_word, model_word());
  endtask

  initial begin
    model_reset();
    reset    = 1'b1;
    uart_enb = 1'b1;
    rx       = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_state", {30'b0, read_state_out}, 32'd0);
    checkOutput("reset_count", {28'b0, sample_count}, 32'd0);
    checkOutput("reset_wb_data", {24'b0, wb_data}, 32'd0);
    checkOutput("reset_wb_flag", {31'b0, wb_flag}, 32'd0);
    checkOutput("reset_word_valid", {31'b0, word_valid}, 32'd0);
    checkOutput("reset_word_data", word_data, 32'd0);
    checkOutput("reset_frame_error", {31'b0, frame_error}, 32'd0);
    wait_ticks(5);

    // single byte
    applyStimulus(8'h5A, 1'b1);

    // a full word; the model carries one lane over from 0x5A
    applyStimulus(8'h78, 1'b1);
    applyStimulus(8'h56, 1'b1);
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h12, 1'b1);

    // start glitch
    clear_events();
    rx = 1'b0;
    wait_ticks(2);
    checkOutput("glitch_in_start", {30'b0, read_state_out}, 32'd1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(14);
    checkOutput("glitch_back_idle", {30'b0, read_state_out}, 32'd0);
    checkOutput("glitch_wb", wb_pulses, 32'd0);
    checkOutput("glitch_fe", fe_pulses, 32'd0);

    // word resync after a framing error
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h03, 1'b1);
    applyStimulus(8'h04, 1'b1);
`ifdef UART_RX_WORD_PACK_EN
    checkOutput("word_04030201", last_word, 32'h04030201);
`else
    checkOutput("word_nopack", word_data, 32'h0);
`endif

    // disable mid-frame
    clear_events();
    applyStimulus(8'h9C, 1'b1);
    clear_events();
    rx = 1'b0;
    wait_ticks(OS + 20);
    uart_enb = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("enb_abort_state", {30'b0, read_state_out}, 32'd0);
    checkOutput("enb_abort_count", {28'b0, sample_count}, 32'd0);
    rx = 1'b1;
    wait_ticks(5);
    uart_enb = 1'b1;
    wait_ticks(OS * 2);
    checkOutput("enb_abort_wb", wb_pulses, 32'd0);
    checkOutput("enb_abort_fe", fe_pulses, 32'd0);
    m_idx = 0;

    // reset during DATA bit 3 of 0xC3
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 3; i++) begin
      rx = (i < 2) ? 1'b1 : 1'b0;
      wait_ticks(OS);
    end
    rx = 1'b0;
    wait_ticks(8);
    checkOutput("pre_reset_state", {30'b0, read_state_out}, 32'd2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    rx    = 1'b1;
    model_reset();
    checkOutput("midreset_state", {30'b0, read_state_out}, 32'd0);
    checkOutput("midreset_count", {28'b0, sample_count}, 32'd0);
    checkOutput("midreset_wb_data", {24'b0, wb_data}, 32'd0);
    checkOutput("midreset_word", word_data, 32'd0);
    wait_ticks(OS);
    applyStimulus(8'hC3, 1'b1);

    // randomized frames, occasional bad stop bit
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      logic       s;
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 5) != 0);
      applyStimulus(b, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
